// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - binary-to-BCD converter and multiplexed 7-segment scan driver
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits)
module seg7_scan_display #(
  parameter int DATA_W   = 9,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              load_i,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < n; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10_m1(DIGITS);

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              overflow_q, overflow_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    bcd_adj    = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          bin_d   = data_i;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 64'(data_i) > MAX_VAL;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Truncation drops the carry out of the top nibble.
        bcd_d = BCD_W'({bcd_adj, bin_q[DATA_W-1]});
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d     = bcd_q;
        overflow_d = ovf_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      pre_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
    end
  end

  logic [3:0] nib;
  logic       blank;

  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) nib = disp_q[4*i +: 4];
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every more significant one are zero.
    blank = (idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0) blank = 1'b0;
    end
`endif
    if (overflow_q)  seg_o = 7'b1000000;
    else if (blank)  seg_o = 7'b0000000;
    else             seg_o = decode(nib);
    an_o        = '0;
    an_o[idx_q] = 1'b1;
  end

  assign busy_o     = (state_q != S_IDLE);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display
module tb_seg7_scan_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] data1;
  logic       load1, busy1, ovf1;
  logic [6:0] seg1;
  logic [2:0] an1;
  logic [6:0] data2;
  logic       load2, busy2, ovf2;
  logic [6:0] seg2;
  logic [1:0] an2;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;
  int exp1_val = 0, exp2_val = 0;
  bit exp1_ovf = 0, exp2_ovf = 0;
  logic [6:0] dec_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  always #5 clk = ~clk;

  seg7_scan_display #(.DATA_W(9), .DIGITS(3), .SCAN_DIV(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data1), .load_i(load1),
    .busy_o(busy1), .overflow_o(ovf1), .seg_o(seg1), .an_o(an1));

  seg7_scan_display #(.DATA_W(7), .DIGITS(2), .SCAN_DIV(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .data_i(data2), .load_i(load2),
    .busy_o(busy2), .overflow_o(ovf2), .seg_o(seg2), .an_o(an2));

  // Clock edges elapsed since reset released: drives the expected scan position.
  always @(posedge clk) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, expv, t);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int val, input bit ovf, input int k);
    int p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    if (ovf) return 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && val < p) return 7'b0000000;
`endif
    return dec_tab[(val / p) % 10];
  endfunction

  task automatic check_all();
    int i1, i2;
    i1 = (t / 4) % 3;
    i2 = (t / 4) % 2;
    chk("an1", 32'(an1), 32'(1 << i1));
    chk("seg1", 32'(seg1), 32'(exp_seg(exp1_val, exp1_ovf, i1)));
    chk("ovf1", 32'(ovf1), 32'(exp1_ovf));
    chk("an2", 32'(an2), 32'(1 << i2));
    chk("seg2", 32'(seg2), 32'(exp_seg(exp2_val, exp2_ovf, i2)));
    chk("ovf2", 32'(ovf2), 32'(exp2_ovf));
  endtask

  task automatic hold(input int c);
    repeat (c) begin
      @(negedge clk);
      check_all();
    end
  endtask

  // Load val into one DUT; optional second load of val2 after at2 busy cycles must be ignored.
  task automatic convert(input int dut, input int val, input int val2, input int at2);
    int n;
    if (dut == 1) begin data1 = 9'(val); load1 = 1'b1; end
    else          begin data2 = 7'(val); load2 = 1'b1; end
    @(negedge clk);
    load1 = 1'b0;
    load2 = 1'b0;
    n = 0;
    while (((dut == 1) ? busy1 : busy2) && n < 40) begin
      check_all();
      n++;
      if (n == at2) begin
        if (dut == 1) begin data1 = 9'(val2); load1 = 1'b1; end
        else          begin data2 = 7'(val2); load2 = 1'b1; end
      end else begin
        load1 = 1'b0;
        load2 = 1'b0;
      end
      @(negedge clk);
    end
    load1 = 1'b0;
    load2 = 1'b0;
    chk($sformatf("busy_cycles%0d", dut), 32'(n), (dut == 1) ? 32'd10 : 32'd8);
    if (dut == 1) begin exp1_val = val; exp1_ovf = (val > 999); end
    else          begin exp2_val = val; exp2_ovf = (val > 99); end
    check_all();
  endtask

  initial begin
    rst = 1'b1; load1 = 1'b0; load2 = 1'b0; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy1", 32'(busy1), 32'd0);
    chk("reset_busy2", 32'(busy2), 32'd0);
    chk("reset_seg1", 32'(seg1), 32'b0111111);
    check_all();

    convert(1, 14, 0, 0);   hold(12);
    convert(1, 511, 0, 0);  hold(12);
    convert(1, 0, 0, 0);    hold(12);
    convert(2, 100, 0, 0);  hold(8);
    convert(2, 99, 0, 0);   hold(8);
    convert(1, 14, 200, 3); hold(14);

    // Reset in the middle of a conversion: nothing may commit.
    data1 = 9'd255; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    hold(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp1_val = 0; exp1_ovf = 0; exp2_val = 0; exp2_ovf = 0;
    chk("abort_busy1", 32'(busy1), 32'd0);
    chk("abort_an1", 32'(an1), 32'd1);
    check_all();
    hold(16);

    for (int k = 0; k < 16; k++) begin
      convert(1, int'($urandom_range(0, 511)), 0, 0);
      hold(int'($urandom_range(1, 13)));
    end
    for (int k = 0; k < 10; k++) begin
      convert(2, int'($urandom_range(0, 127)), 0, 0);
      hold(int'($urandom_range(1, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
